// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam logic [3:0]  ADD3_THRESH = 4'd5;
  localparam logic [3:0]  BCD_NINE    = 4'h9;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/busy/done handshake and result bus of the binary-to-BCD converter.
interface bin_to_bcd_seq_if #(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) ();
  import seg_pkg::*;

  logic                          start;
  logic [BIN_W-1:0]              bin;
  logic                          busy;
  logic                          done;
  logic [BCD_DIGIT_W*DIGITS-1:0] bcd;
  logic                          overflow;

  modport master (
    output start, bin,
    input  busy, done, bcd, overflow
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, overflow
  );

endinterface

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// One double-dabble digit correction: add 3 when the digit is 5 or more.
module bcd_digit_adj
  import seg_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  // 4-bit add, no carry out: a digit <= 9 never exceeds 12 after correction
  always_comb begin
    dout = (din >= ADD3_THRESH) ? din + 4'd3 : din;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock (shift-add-3).
module bin_to_bcd_seq
  import seg_pkg::*;
#(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  bin_to_bcd_seq_if.slave bus
);

  localparam int unsigned BCD_W    = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CNT_W    = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  state_t             state, state_nxt;
  logic [BIN_W-1:0]   shreg;
  logic [BCD_W-1:0]   scratch;
  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   scratch_sh;
  logic               ovf;
  logic               ovf_sh;
  logic [CNT_W-1:0]   cnt;
  logic [BCD_W-1:0]   bcd_q;
  logic               ovf_q;
  logic               busy_c;
  logic               done_c;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Corrected scratch shifted left with the next binary bit entering at the bottom
  always_comb begin
    scratch_sh = {adj[BCD_W-2:0], shreg[BIN_W-1]};
    ovf_sh     = ovf | adj[BCD_W-1];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy_c = 1'b1;
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        busy_c    = 1'b1;
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register, scratch digits, bit counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      scratch <= '0;
      ovf     <= 1'b0;
      cnt     <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            shreg   <= bus.bin;
            scratch <= '0;
            ovf     <= 1'b0;
            cnt     <= CNT_LAST;
          end
        end
        SHIFT: begin
          shreg   <= shreg << 1;
          scratch <= scratch_sh;
          ovf     <= ovf_sh;
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            // Result registered from the final shift on the edge entering DONE,
            // so it is already visible during the done cycle.
            bcd_q <= ovf_sh ? {DIGITS{BCD_NINE}} : scratch_sh;
            ovf_q <= ovf_sh;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = busy_c;
  assign bus.done     = done_c;
  assign bus.bcd      = bcd_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: decimal reference model plus directed vectors.
module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  bin_to_bcd_seq_if #(.BIN_W(8), .DIGITS(3)) if3 ();
  bin_to_bcd_seq_if #(.BIN_W(8), .DIGITS(2)) if2 ();

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));
  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Decimal conversion by division; saturates to all nines when the value does not fit.
  function automatic logic [12:0] golden(input int v, input int nd);
    logic [11:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    if (x > 0) begin
      r = '0;
      for (int i = 0; i < nd; i++) r[4*i +: 4] = 4'h9;
    end
    return {(x > 0), r};
  endfunction

  // Reference model: an accepted start keeps the block busy for BIN_W+1 cycles, done on the last.
  int          m3_rem = 0, m2_rem = 0;
  logic [7:0]  m3_cap = '0, m2_cap = '0;
  logic [11:0] m3_bcd = '0;
  logic [7:0]  m2_bcd = '0;
  logic        m3_ovf = 1'b0, m2_ovf = 1'b0;
  logic [12:0] g3, g2;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m3_rem = 0; m3_bcd = '0; m3_ovf = 1'b0;
      m2_rem = 0; m2_bcd = '0; m2_ovf = 1'b0;
    end else begin
      if (m3_rem != 0) begin
        m3_rem--;
        if (m3_rem == 1) begin
          g3 = golden(int'(m3_cap), 3);
          m3_bcd = g3[11:0];
          m3_ovf = g3[12];
        end
      end else if (if3.start) begin
        m3_cap = if3.bin;
        m3_rem = 9;
      end
      if (m2_rem != 0) begin
        m2_rem--;
        if (m2_rem == 1) begin
          g2 = golden(int'(m2_cap), 2);
          m2_bcd = g2[7:0];
          m2_ovf = g2[12];
        end
      end else if (if2.start) begin
        m2_cap = if2.bin;
        m2_rem = 9;
      end
    end
  end

  // Compare both DUTs against the model every cycle outside reset
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy3", if3.busy, m3_rem != 0);
      chk("done3", if3.done, m3_rem == 1);
      chk("bcd3",  if3.bcd, m3_bcd);
      chk("ovf3",  if3.overflow, m3_ovf);
      chk("busy2", if2.busy, m2_rem != 0);
      chk("done2", if2.done, m2_rem == 1);
      chk("bcd2",  if2.bcd, m2_bcd);
      chk("ovf2",  if2.overflow, m2_ovf);
    end
  end

  task automatic conv3(input logic [7:0] v, input logic [11:0] exp, output int dcyc);
    int nb;
    bit seen;
    nb = 0; seen = 0; dcyc = 0;
    @(negedge clk);
    if3.start = 1'b1;
    if3.bin   = v;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (i == 0) begin
        if3.start = 1'b0;
        if3.bin   = ~v;
      end
      if (if3.busy) nb++;
      if (if3.done) begin
        seen = 1;
        dcyc = cyc;
        chk("bcd3_lit", if3.bcd, exp);
      end
    end
    chk("done3_seen", seen, 1);
    chk("busy3_cycles", nb, 9);
  endtask

  task automatic conv2(input logic [7:0] v, input logic [7:0] exp, input logic eovf);
    bit seen;
    seen = 0;
    @(negedge clk);
    if2.start = 1'b1;
    if2.bin   = v;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (i == 0) if2.start = 1'b0;
      if (if2.done) begin
        seen = 1;
        chk("bcd2_lit", if2.bcd, exp);
        chk("ovf2_lit", if2.overflow, eovf);
      end
    end
    chk("done2_seen", seen, 1);
  endtask

  initial begin
    int dc, prev, nd;
    logic [12:0] gv;
    logic [11:0] got;
    rst_n = 1'b0;
    if3.start = 1'b0; if3.bin = '0;
    if2.start = 1'b0; if2.bin = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", if3.busy, 0);
    chk("rst_done", if3.done, 0);
    chk("rst_bcd",  if3.bcd, 0);
    chk("rst_ovf",  if3.overflow, 0);
    rst_n = 1'b1;

    conv3(8'd0,   12'h000, dc);
    conv3(8'd99,  12'h099, dc);
    conv3(8'd255, 12'h255, dc);

    conv2(8'd200, 8'h99, 1'b1);
    conv2(8'd42,  8'h42, 1'b0);

    // Exhaustive back-to-back: each start issued the cycle after the previous done
    prev = 0;
    for (int v = 0; v < 256; v++) begin
      gv = golden(v, 3);
      conv3(8'(v), gv[11:0], dc);
      if (v > 0) chk("spacing", dc - prev, 10);
      prev = dc;
    end

    // start held/pulsed with other values during SHIFT is ignored
    @(negedge clk);
    if3.start = 1'b1; if3.bin = 8'd123;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if3.bin = 8'(45 + i * 17);
      if3.start = (i != 2);
    end
    @(negedge clk);
    if3.start = 1'b0;
    nd = 0; got = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if3.done) begin nd++; got = if3.bcd; end
    end
    chk("ignore_ndone", nd, 1);
    chk("ignore_bcd", got, 12'h123);

    // Asynchronous reset in the middle of SHIFT aborts the conversion
    @(negedge clk);
    if3.start = 1'b1; if3.bin = 8'd200;
    @(negedge clk);
    if3.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", if3.busy, 0);
    chk("arst_done", if3.done, 0);
    chk("arst_bcd",  if3.bcd, 0);
    chk("arst_ovf",  if3.overflow, 0);
    chk("arst_bcd2", if2.bcd, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (if3.done) nd++;
    end
    chk("arst_nodone", nd, 0);
    conv3(8'd7, 12'h007, dc);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
